fetch_queue: RTL and testbench
==============================

# fetch_queue

Parametrised instruction fetch queue between the AXI instruction-side interface and the decode stage register. It decouples bus latency from the pipeline: it buffers returned instructions with their PC, issues credit-based fetch permission, and on a redirect (branch or exception) it discards both buffered entries and responses still in flight. It replaces the direct `instrF`/`i_stall` coupling with a valid/ready decode interface.

## Interface
Parameters:
- `DEPTH`, 4: queue entries; power of two, ≥2.
- `MAX_OUT`, 2: maximum outstanding fetch requests; ≥1, ≤DEPTH.
- `FALLTHROUGH`, 0: 1 = a response arriving while the queue is empty is presented on the output in the same cycle; 0 = always registered.

Ports (one clock; reset is synchronous and active-low):
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous active-low reset.
- `flush` in 1: redirect; empties the queue and marks all in-flight requests for discard.
- `req_allow` out 1: a new fetch request may be issued this cycle.
- `req_fire` in 1: fetch request accepted by the bus this cycle.
- `in_valid` in 1: instruction response this cycle; exactly one per earlier `req_fire`, in order.
- `in_pc` in 32: PC of the response.
- `in_instr` in 32: instruction word.
- `out_valid` out 1: head entry valid toward decode.
- `out_ready` in 1: decode accepts the head (`~stallD`).
- `out_pc`, `out_instr` out 32: head entry.
- `out_pcplus4` out 32: `out_pc + 4`, wraps modulo 2^32.
- `out_adel` out 1: `out_pc[1:0] != 0`.
- `count` out $clog2(DEPTH)+1: current occupancy.

## Operation
- State: `head`, `tail` pointers ($clog2(DEPTH) bits, wrap at DEPTH); `cnt` (0..DEPTH); outstanding `ost` (0..MAX_OUT); discard count `dis` (0..MAX_OUT).
- `req_allow = (cnt + ost < DEPTH) && (ost < MAX_OUT)`, from registered state only. No same-cycle pop credit.
- `req_fire` while `req_allow=0` is a protocol error: ignored, `ost` unchanged.
- Outstanding count: `ost_next = ost + req_fire - in_valid`. `in_valid` with `ost=0` is ignored.
- Response handling:
  - If `dis>0`, the response is dropped and `dis` decrements.
  - Otherwise it is pushed at `tail`, unless it is bypassed (FALLTHROUGH=1, `cnt=0`, `out_ready=1`).
- The credit rule guarantees a push never occurs at `cnt=DEPTH`.
- Pop: `out_valid && out_ready` advances `head`. Simultaneous push and pop leave `cnt` unchanged.
- `out_valid = ~flush && (cnt!=0 || (FALLTHROUGH && in_valid && dis==0))`. When empty with fallthrough, the outputs carry the `in_*` values.
- Flush:
  - `head`, `tail` and `cnt` are set to 0.
  - `dis_next = ost_next`: every request still outstanding, including one fired in the flush cycle, will be discarded.
  - A response arriving in the flush cycle is dropped.
  - No pop occurs in the flush cycle.
- Flush has priority over push and pop. Reset has priority over everything.

## Timing
- Reset values:
  - `head`, `tail`, `cnt`, `ost`, `dis` = 0.
  - `out_valid` = 0 and `count` = 0.
  - `req_allow` = 1.
  - `out_pc`, `out_instr` = 0: storage is cleared.
- Latency: with FALLTHROUGH=0, a push in cycle N gives `out_valid` in N+1. With FALLTHROUGH=1 and the queue empty, the response is visible in cycle N.
- `count`, `req_allow` and the `out_*` data update one cycle after the triggering edge. Only the fallthrough path is combinational from inputs.
- A reset asserted mid-operation drops all state in one edge. Responses from before the reset are not discarded; the bus side is reset together with this block.
- Throughput: one push and one pop per cycle sustained, provided `DEPTH ≥ MAX_OUT + 1`.

## Structure
- Shared `defines.vh` holds the entry-width constant (32 + 32) and the `FALLTHROUGH` mode constants.
- One sub-module, `fq_ram`: a DEPTH×64 register array with one write port and one asynchronous read port, synchronous active-low clear.
- Pointer, count and discard logic live in `fetch_queue`.

## Test plan
- Reset, then idle: `req_allow=1`, `out_valid=0`, `count=0`. Push `pc=0xBFC00000`, `instr=0x24080001` → next cycle `out_valid=1`, `out_pcplus4=0xBFC00004`, `out_adel=0`.
- DEPTH=4, MAX_OUT=2, `out_ready=0`, continuous fetching → exactly 4 entries accepted, `req_allow` drops when `cnt+ost=4`, no entry lost. Releasing `out_ready` pops them in PC order.
- Two requests outstanding, `flush` pulsed → `count=0` next cycle, the next two responses dropped. A third request fired after the flush returns `pc=0xBFC00380` and appears at the head.
- Flush in the same cycle as a `req_fire` and an `in_valid` → `dis=ost_next`. The in-cycle response and the new request's response are both dropped.
- FALLTHROUGH=1, empty queue, `in_valid` with `pc=0x80000000` and `out_ready=1` → `out_valid=1` in the same cycle, `count` stays 0.
- `in_pc=0xBFC00002` → `out_adel=1`. `in_pc=0xFFFFFFFC` → `out_pcplus4=0x00000000`.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared types and constants for the instruction fetch queue.
//   ENTRY_W        width of one queue entry (PC + instruction word)
//   FT_REGISTERED  FALLTHROUGH value: responses always pass through storage
//   FT_BYPASS      FALLTHROUGH value: a response into an empty queue is shown
//                  on the output in the cycle it arrives
//   fq_entry_t     one queue entry
//   next_pc()      sequential successor PC, wraps modulo 2^32
//   pc_misaligned() nonzero low PC bits (address error on fetch)
package fetch_queue_pkg;

  localparam int ENTRY_W       = 32 + 32;
  localparam int FT_REGISTERED = 0;
  localparam int FT_BYPASS     = 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  function automatic logic pc_misaligned(input logic [31:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: fetch-side and decode-side handshake of the fetch queue.
//   req_allow / req_fire             credit-based fetch request permission
//   in_valid / in_pc / in_instr      instruction response from the bus
//   out_valid / out_ready            head entry handshake toward decode
//   out_pc / out_instr / out_pcplus4 / out_adel  head entry and derived fields
// Modport slave is taken by the queue; master by whoever drives the bus and
// decode sides.
interface fetch_queue_if;

  logic        req_allow;
  logic        req_fire;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [31:0] out_pcplus4;
  logic        out_adel;

  modport slave (
    input  req_fire, in_valid, in_pc, in_instr, out_ready,
    output req_allow, out_valid, out_pc, out_instr, out_pcplus4, out_adel
  );

  modport master (
    output req_fire, in_valid, in_pc, in_instr, out_ready,
    input  req_allow, out_valid, out_pc, out_instr, out_pcplus4, out_adel
  );

endinterface

// File: rtl/fetch_queue_fq_ram.sv
// fq_ram: DEPTH x ENTRY_W register array for the fetch queue.
//   clk, rst (sync, active-low: clears every entry)
//   we, waddr, wdata   single write port
//   raddr, rdata       asynchronous read port
module fq_ram
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  fq_entry_t                wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output fq_entry_t                rdata
);

  fq_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch queue between the instruction bus and decode.
//   clk    clock, rising edge
//   rst    synchronous active-low reset
//   flush  redirect: empties the queue, discards every in-flight response
//   bus    fetch_queue_if.slave (request credit, responses, decode handshake)
//   count  current occupancy
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int MAX_OUT     = 2,
  parameter int FALLTHROUGH = FT_REGISTERED
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  fetch_queue_if.slave           bus,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OST_W = $clog2(MAX_OUT + 1);
  localparam int SUM_W = CNT_W + 1;

  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] cnt;
  logic [OST_W-1:0] ost, dis, ost_next;
  logic [SUM_W-1:0] occ;

  logic fire, resp, drop, accept, bypass, push, pop;
  fq_entry_t wr_entry, rd_entry, head_entry;

  // Credit counts both stored entries and responses still on their way, so a
  // push can never find the queue full.
  assign occ           = SUM_W'(cnt) + SUM_W'(ost);
  assign bus.req_allow = (occ < SUM_W'(DEPTH)) && (ost < OST_W'(MAX_OUT));

  assign fire     = bus.req_fire && bus.req_allow;
  assign resp     = bus.in_valid && (ost != '0);
  assign ost_next = ost + OST_W'(fire) - OST_W'(resp);
  assign drop     = resp && (dis != '0);
  assign accept   = resp && (dis == '0) && !flush;
  assign bypass   = (FALLTHROUGH != 0) && (cnt == '0) && bus.out_ready && accept;
  assign push     = accept && !bypass;
  assign pop      = bus.out_valid && bus.out_ready && (cnt != '0);

  assign wr_entry = '{pc: bus.in_pc, instr: bus.in_instr};

  fq_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (push),
    .waddr (tail),
    .wdata (wr_entry),
    .raddr (head),
    .rdata (rd_entry)
  );

  // With fallthrough an empty queue shows the live response instead of storage.
  always_comb begin
    head_entry = rd_entry;
    if ((FALLTHROUGH != 0) && (cnt == '0)) head_entry = wr_entry;
  end

  assign bus.out_valid   = !flush &&
                           ((cnt != '0) ||
                            ((FALLTHROUGH != 0) && bus.in_valid && (dis == '0)));
  assign bus.out_pc      = head_entry.pc;
  assign bus.out_instr   = head_entry.instr;
  assign bus.out_pcplus4 = next_pc(head_entry.pc);
  assign bus.out_adel    = pc_misaligned(head_entry.pc);
  assign count           = cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      ost  <= '0;
      dis  <= '0;
    end else if (flush) begin
      // Everything still outstanding after this edge, including a request
      // fired right now, belongs to the abandoned path.
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      ost  <= ost_next;
      dis  <= ost_next;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (!push && pop) cnt <= cnt - 1'b1;
      ost <= ost_next;
      if (drop) dis <= dis - 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush0, flush1;
  logic [2:0] count0, count1;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  fetch_queue_if ifc0 ();
  fetch_queue_if ifc1 ();

  fetch_queue #(.DEPTH(4), .MAX_OUT(2), .FALLTHROUGH(0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush0), .bus(ifc0), .count(count0)
  );

  fetch_queue #(.DEPTH(4), .MAX_OUT(2), .FALLTHROUGH(1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush1), .bus(ifc1), .count(count1)
  );

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_all();
    ifc0.req_fire = 0; ifc0.in_valid = 0; ifc0.in_pc = 0; ifc0.in_instr = 0;
    ifc0.out_ready = 0; flush0 = 0;
    ifc1.req_fire = 0; ifc1.in_valid = 0; ifc1.in_pc = 0; ifc1.in_instr = 0;
    ifc1.out_ready = 0; flush1 = 0;
  endtask

  // One request, its response in the following cycle, decode stalled.
  task automatic fetch0(input logic [31:0] pc, input logic [31:0] instr);
    ifc0.req_fire = 1;
    step();
    ifc0.req_fire = 0;
    ifc0.in_valid = 1; ifc0.in_pc = pc; ifc0.in_instr = instr;
    step();
    ifc0.in_valid = 0;
    #1;
  endtask

  task automatic pop0();
    ifc0.out_ready = 1;
    step();
    ifc0.out_ready = 0;
    #1;
  endtask

  task automatic test_reset();
    rst = 0;
    idle_all();
    step();
    step();
    rst = 1;
    #1;
    checks++; if (ifc0.req_allow !== 1'b1) begin errors++; $display("FAIL reset_req_allow got %0h exp 1", ifc0.req_allow); end
    checks++; if (ifc0.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0h exp 0", ifc0.out_valid); end
    checks++; if (count0 !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count0); end
    checks++; if (ifc0.out_pc !== 32'h0) begin errors++; $display("FAIL reset_out_pc got %08h exp 00000000", ifc0.out_pc); end
    checks++; if (ifc0.out_instr !== 32'h0) begin errors++; $display("FAIL reset_out_instr got %08h exp 00000000", ifc0.out_instr); end
    checks++; if (count1 !== 3'd0) begin errors++; $display("FAIL reset_count_ft got %0d exp 0", count1); end
  endtask

  task automatic test_single();
    ifc0.req_fire = 1;
    step();
    ifc0.req_fire = 0;
    ifc0.in_valid = 1; ifc0.in_pc = 32'hBFC00000; ifc0.in_instr = 32'h24080001;
    #1;
    checks++; if (ifc0.out_valid !== 1'b0) begin errors++; $display("FAIL single_not_bypassed got %0h exp 0", ifc0.out_valid); end
    step();
    ifc0.in_valid = 0;
    #1;
    checks++; if (ifc0.out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid got %0h exp 1", ifc0.out_valid); end
    checks++; if (ifc0.out_pc !== 32'hBFC00000) begin errors++; $display("FAIL single_out_pc got %08h exp bfc00000", ifc0.out_pc); end
    checks++; if (ifc0.out_instr !== 32'h24080001) begin errors++; $display("FAIL single_out_instr got %08h exp 24080001", ifc0.out_instr); end
    checks++; if (ifc0.out_pcplus4 !== 32'hBFC00004) begin errors++; $display("FAIL single_pcplus4 got %08h exp bfc00004", ifc0.out_pcplus4); end
    checks++; if (ifc0.out_adel !== 1'b0) begin errors++; $display("FAIL single_adel got %0h exp 0", ifc0.out_adel); end
    checks++; if (count0 !== 3'd1) begin errors++; $display("FAIL single_count got %0d exp 1", count0); end
    pop0();
    checks++; if (count0 !== 3'd0) begin errors++; $display("FAIL single_pop_count got %0d exp 0", count0); end
    checks++; if (ifc0.out_valid !== 1'b0) begin errors++; $display("FAIL single_pop_valid got %0h exp 0", ifc0.out_valid); end
  endtask

  // Decode stalled, requests offered every cycle, bus answers one cycle later.
  task automatic test_fill();
    logic exp_allow [6];
    logic prev_fired;
    int   k;
    exp_allow = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    prev_fired = 0;
    k = 0;
    for (int i = 0; i < 6; i++) begin
      ifc0.req_fire = 1;
      if (prev_fired) begin
        ifc0.in_valid = 1; ifc0.in_pc = 32'h00001000 + 32'(4 * k); ifc0.in_instr = 32'hA0000000 + 32'(k);
        k++;
      end else begin
        ifc0.in_valid = 0;
      end
      #1;
      checks++; if (ifc0.req_allow !== exp_allow[i]) begin errors++; $display("FAIL fill_req_allow cycle %0d got %0h exp %0h", i, ifc0.req_allow, exp_allow[i]); end
      prev_fired = exp_allow[i];
      step();
    end
    ifc0.req_fire = 0;
    ifc0.in_valid = 0;
    #1;
    checks++; if (count0 !== 3'd4) begin errors++; $display("FAIL fill_count got %0d exp 4", count0); end
    checks++; if (ifc0.req_allow !== 1'b0) begin errors++; $display("FAIL fill_full_allow got %0h exp 0", ifc0.req_allow); end
    ifc0.out_ready = 1;
    for (int j = 0; j < 4; j++) begin
      #1;
      checks++; if (ifc0.out_valid !== 1'b1) begin errors++; $display("FAIL drain_valid %0d got %0h exp 1", j, ifc0.out_valid); end
      checks++; if (ifc0.out_pc !== 32'h00001000 + 32'(4 * j)) begin errors++; $display("FAIL drain_pc %0d got %08h exp %08h", j, ifc0.out_pc, 32'h00001000 + 32'(4 * j)); end
      step();
    end
    ifc0.out_ready = 0;
    #1;
    checks++; if (count0 !== 3'd0) begin errors++; $display("FAIL drain_count got %0d exp 0", count0); end
  endtask

  task automatic test_flush();
    ifc0.req_fire = 1;
    step();
    ifc0.in_valid = 1; ifc0.in_pc = 32'h00002000; ifc0.in_instr = 32'h11110000;
    step();
    ifc0.in_valid = 0;
    #1;
    checks++; if (ifc0.req_allow !== 1'b1) begin errors++; $display("FAIL flush_pre_allow got %0h exp 1", ifc0.req_allow); end
    step();
    ifc0.req_fire = 0;
    flush0 = 1; ifc0.out_ready = 1;
    #1;
    checks++; if (ifc0.out_valid !== 1'b0) begin errors++; $display("FAIL flush_masks_valid got %0h exp 0", ifc0.out_valid); end
    step();
    flush0 = 0; ifc0.out_ready = 0;
    #1;
    checks++; if (count0 !== 3'd0) begin errors++; $display("FAIL flush_count got %0d exp 0", count0); end
    checks++; if (ifc0.req_allow !== 1'b0) begin errors++; $display("FAIL flush_ost_allow got %0h exp 0", ifc0.req_allow); end
    ifc0.in_valid = 1; ifc0.in_pc = 32'hDEAD0000; ifc0.in_instr = 32'hDEADDEAD;
    step();
    ifc0.in_pc = 32'hDEAD0004;
    step();
    ifc0.in_valid = 0;
    #1;
    checks++; if (count0 !== 3'd0) begin errors++; $display("FAIL flush_drop_count got %0d exp 0", count0); end
    checks++; if (ifc0.out_valid !== 1'b0) begin errors++; $display("FAIL flush_drop_valid got %0h exp 0", ifc0.out_valid); end
    checks++; if (ifc0.req_allow !== 1'b1) begin errors++; $display("FAIL flush_after_allow got %0h exp 1", ifc0.req_allow); end
    fetch0(32'hBFC00380, 32'h3C1A8000);
    checks++; if (ifc0.out_valid !== 1'b1) begin errors++; $display("FAIL flush_new_valid got %0h exp 1", ifc0.out_valid); end
    checks++; if (ifc0.out_pc !== 32'hBFC00380) begin errors++; $display("FAIL flush_new_pc got %08h exp bfc00380", ifc0.out_pc); end
    checks++; if (count0 !== 3'd1) begin errors++; $display("FAIL flush_new_count got %0d exp 1", count0); end
    pop0();
  endtask

  task automatic test_flush_same_cycle();
    ifc0.req_fire = 1;
    step();
    ifc0.req_fire = 1; flush0 = 1;
    ifc0.in_valid = 1; ifc0.in_pc = 32'h00003000; ifc0.in_instr = 32'h33330000;
    step();
    ifc0.req_fire = 0; flush0 = 0;
    ifc0.in_pc = 32'h00003004;
    #1;
    checks++; if (count0 !== 3'd0) begin errors++; $display("FAIL samecyc_count got %0d exp 0", count0); end
    step();
    ifc0.in_valid = 0;
    #1;
    checks++; if (count0 !== 3'd0) begin errors++; $display("FAIL samecyc_drop_count got %0d exp 0", count0); end
    checks++; if (ifc0.out_valid !== 1'b0) begin errors++; $display("FAIL samecyc_drop_valid got %0h exp 0", ifc0.out_valid); end
    fetch0(32'h00003008, 32'h33330002);
    checks++; if (count0 !== 3'd1) begin errors++; $display("FAIL samecyc_next_count got %0d exp 1", count0); end
    checks++; if (ifc0.out_pc !== 32'h00003008) begin errors++; $display("FAIL samecyc_next_pc got %08h exp 00003008", ifc0.out_pc); end
    pop0();
  endtask

  task automatic test_fallthrough();
    ifc1.req_fire = 1;
    step();
    ifc1.req_fire = 0;
    ifc1.in_valid = 1; ifc1.in_pc = 32'h80000000; ifc1.in_instr = 32'h11111111;
    ifc1.out_ready = 1;
    #1;
    checks++; if (ifc1.out_valid !== 1'b1) begin errors++; $display("FAIL ft_same_cycle_valid got %0h exp 1", ifc1.out_valid); end
    checks++; if (ifc1.out_pc !== 32'h80000000) begin errors++; $display("FAIL ft_same_cycle_pc got %08h exp 80000000", ifc1.out_pc); end
    checks++; if (ifc1.out_instr !== 32'h11111111) begin errors++; $display("FAIL ft_same_cycle_instr got %08h exp 11111111", ifc1.out_instr); end
    step();
    ifc1.in_valid = 0; ifc1.out_ready = 0;
    #1;
    checks++; if (count1 !== 3'd0) begin errors++; $display("FAIL ft_bypass_count got %0d exp 0", count1); end
    checks++; if (ifc1.out_valid !== 1'b0) begin errors++; $display("FAIL ft_bypass_after_valid got %0h exp 0", ifc1.out_valid); end
    ifc1.req_fire = 1;
    step();
    ifc1.req_fire = 0;
    ifc1.in_valid = 1; ifc1.in_pc = 32'h80000004; ifc1.in_instr = 32'h22222222;
    step();
    ifc1.in_valid = 0;
    #1;
    checks++; if (count1 !== 3'd1) begin errors++; $display("FAIL ft_stalled_count got %0d exp 1", count1); end
    checks++; if (ifc1.out_pc !== 32'h80000004) begin errors++; $display("FAIL ft_stalled_pc got %08h exp 80000004", ifc1.out_pc); end
    ifc1.out_ready = 1;
    step();
    ifc1.out_ready = 0;
  endtask

  task automatic test_boundary();
    fetch0(32'hBFC00002, 32'h00000000);
    checks++; if (ifc0.out_adel !== 1'b1) begin errors++; $display("FAIL adel_misaligned got %0h exp 1", ifc0.out_adel); end
    pop0();
    fetch0(32'hFFFFFFFC, 32'h00000000);
    checks++; if (ifc0.out_pcplus4 !== 32'h00000000) begin errors++; $display("FAIL pcplus4_wrap got %08h exp 00000000", ifc0.out_pcplus4); end
    checks++; if (ifc0.out_adel !== 1'b0) begin errors++; $display("FAIL adel_aligned got %0h exp 0", ifc0.out_adel); end
    pop0();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_flush();
    test_flush_same_cycle();
    test_fallthrough();
    test_boundary();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
